// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared widths and state encodings for the BCD converter scheduler
package bcd_pkg;

    localparam int B_LEN   = 10;
    localparam int BCD_LEN = 16;

    localparam logic [BCD_LEN-1:0] BCD_ERR = '1;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_START = 5'b00010,
        S_WAIT  = 5'b00100,
        S_ABORT = 5'b01000,
        S_STORE = 5'b10000
    } state_t;

endpackage

// File: rtl/bcd_conv_scheduler_rr_pick.sv
// rtl/bcd_conv_scheduler_rr_pick.sv - combinational round-robin picker over pending requests
module rr_pick #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] pending,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] grant,
    output logic            valid
);
    import bcd_pkg::*;

    logic [CH_W-1:0] idx;

    // Scan from the farthest offset down so the nearest set bit at/after ptr wins last
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(ptr) + i) % N_CH);
            if (pending[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// rtl/bcd_conv_scheduler.sv - round-robin sharing of one binary-to-BCD converter between channels
module bcd_conv_scheduler #(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int B_LEN   = bcd_pkg::B_LEN,
    parameter int BCD_LEN = bcd_pkg::BCD_LEN,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH*B_LEN-1:0]   bin_in,
    output logic [N_CH-1:0]         ack,
    output logic [N_CH*BCD_LEN-1:0] bcd_out,
    output logic [N_CH-1:0]         err,
    output logic                    conv_start,
    output logic [B_LEN-1:0]        conv_bin,
    input  logic                    conv_done,
    input  logic [BCD_LEN-1:0]      conv_bcd,
    output logic                    busy
);
    import bcd_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t               state, state_d;
    logic [CH_W-1:0]      gnt, g, ptr;
    logic                 gnt_vld;
    logic [N_CH-1:0]      pending, clr_mask;
    logic [BCD_LEN-1:0]   result;
    logic [TW-1:0]        timer;
    logic                 timed_out, storing;
    logic [B_LEN-1:0]     bin_arr [N_CH];
    logic [BCD_LEN-1:0]   bcd_reg [N_CH];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign bin_arr[c]                       = bin_in[c*B_LEN +: B_LEN];
        assign bcd_out[c*BCD_LEN +: BCD_LEN]    = bcd_reg[c];
    end

    rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .grant   (gnt),
        .valid   (gnt_vld)
    );

    assign busy      = (state != S_IDLE);
    assign timed_out = (timer == TW'(TIMEOUT - 1));
    assign storing   = (state == S_STORE) || (state == S_ABORT);

    // Next-state decision and the pending-clear mask for the channel being retired
    always_comb begin
        state_d  = state;
        clr_mask = '0;
        case (state)
            S_IDLE: begin
                if (gnt_vld) begin
                    state_d = (bin_arr[gnt] == '0) ? S_STORE : S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (conv_done) begin
                    state_d = S_STORE;
                end else if (timed_out) begin
                    state_d = S_ABORT;
                end
            end
            S_STORE, S_ABORT: begin
                state_d     = S_IDLE;
                clr_mask[g] = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath: request latching, converter sequencing, result capture and per-channel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            ptr        <= '0;
            g          <= '0;
            result     <= '0;
            timer      <= '0;
            ack        <= '0;
            err        <= '0;
            conv_start <= 1'b0;
            conv_bin   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                bcd_reg[c] <= '0;
            end
        end else begin
            ack        <= '0;
            conv_start <= 1'b0;
            // a new request in the clearing cycle keeps the channel pending
            pending    <= (pending & ~clr_mask) | req;
            case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        g <= gnt;
                        // zero never starts the converter, so its result is known now
                        if (bin_arr[gnt] == '0) begin
                            result <= '0;
                        end else begin
                            conv_bin   <= bin_arr[gnt];
                            conv_start <= 1'b1;
                        end
                    end
                end
                S_START: timer <= '0;
                S_WAIT: begin
                    if (conv_done) begin
                        result <= conv_bcd;
                    end else if (timed_out) begin
                        result <= {BCD_LEN{1'b1}};
                        err[g] <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: ;
            endcase
            if (storing) begin
                bcd_reg[g] <= result;
                ack[g]     <= 1'b1;
                ptr        <= (g == CH_W'(N_CH - 1)) ? '0 : g + CH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb/tb_bcd_conv_scheduler.sv - self-checking bench for bcd_conv_scheduler
module tb_bcd_conv_scheduler;

    localparam int L = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] bin_in;
    logic [3:0]  ack;
    logic [63:0] bcd_out;
    logic [3:0]  err;
    logic        conv_start;
    logic [9:0]  conv_bin;
    logic        conv_done;
    logic [15:0] conv_bcd;
    logic        busy;

    int cyc = 0;
    int ack_ch_q[$], ack_cyc_q[$], start_cyc_q[$], done_cyc_q[$];
    bit silent = 1'b0;
    int cnt = 0;
    logic [9:0] lat_bin = '0;
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] model_bcd [4];
    int model_ptr;

    bcd_conv_scheduler #(
        .N_CH (4), .CH_W (2), .B_LEN (10), .BCD_LEN (16), .TIMEOUT (255)
    ) dut (
        .clk (clk), .rst (rst), .req (req), .bin_in (bin_in),
        .ack (ack), .bcd_out (bcd_out), .err (err),
        .conv_start (conv_start), .conv_bin (conv_bin),
        .conv_done (conv_done), .conv_bcd (conv_bcd), .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] get_bcd(input int c);
        logic [63:0] t;
        t = bcd_out >> (16 * c);
        return t[15:0];
    endfunction

    // monitor: record acks and start pulses per cycle
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (ack[c] === 1'b1) begin
                ack_ch_q.push_back(c);
                ack_cyc_q.push_back(cyc);
            end
        end
        if (conv_start === 1'b1) start_cyc_q.push_back(cyc);
    end

    // converter model: fixed latency L after the start pulse, or silent
    always @(negedge clk) begin
        conv_done = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                conv_done = 1'b1;
                conv_bcd  = to_bcd(int'(lat_bin));
                done_cyc_q.push_back(cyc);
            end
        end
        if (conv_start === 1'b1 && !silent) begin
            cnt     = L;
            lat_bin = conv_bin;
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q;
        ack_ch_q.delete(); ack_cyc_q.delete(); start_cyc_q.delete(); done_cyc_q.delete();
    endtask

    task automatic set_op(input int c, input int v);
        bin_in = (bin_in & ~(40'h3FF << (c * 10))) | (40'(v & 1023) << (c * 10));
    endtask

    task automatic pulse_req(input logic [3:0] m, output int c0);
        step;
        req = m;
        c0  = cyc;
        step;
        req = '0;
    endtask

    task automatic apply_reset;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        clear_q();
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; bin_in = '0;
        repeat (3) step;
        rst = 1'b0;
        vectors++; if (ack !== 4'h0) begin miscompares++; $display("FAIL reset_ack got %h exp 0", ack); end
        vectors++; if (bcd_out !== 64'h0) begin miscompares++; $display("FAIL reset_bcd got %h exp 0", bcd_out); end
        vectors++; if (err !== 4'h0) begin miscompares++; $display("FAIL reset_err got %h exp 0", err); end
        vectors++; if (conv_start !== 1'b0) begin miscompares++; $display("FAIL reset_start got %b exp 0", conv_start); end
        vectors++; if (conv_bin !== 10'h0) begin miscompares++; $display("FAIL reset_bin got %h exp 0", conv_bin); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        clear_q();
        repeat (5) step;
        vectors++; if (ack_ch_q.size() != 0) begin miscompares++; $display("FAIL idle_no_ack got %0d exp 0", ack_ch_q.size()); end
    endtask

    task automatic test_single;
        int c0;
        set_op(1, 987);
        pulse_req(4'b0010, c0);
        repeat (40) step;
        vectors++; if (start_cyc_q.size() != 1) begin miscompares++; $display("FAIL single_starts got %0d exp 1", start_cyc_q.size()); end
        vectors++; if ((start_cyc_q.size() > 0 ? start_cyc_q[0] : -1) != c0 + 2) begin miscompares++; $display("FAIL single_start_cyc got %0d exp %0d", (start_cyc_q.size() > 0 ? start_cyc_q[0] : -1), c0 + 2); end
        vectors++; if (ack_ch_q.size() != 1 || ack_ch_q[0] != 1) begin miscompares++; $display("FAIL single_ack_ch got n=%0d exp one ack on ch1", ack_ch_q.size()); end
        vectors++; if ((ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1) != c0 + 24 || done_cyc_q.size() != 1 || ack_cyc_q[0] != done_cyc_q[0] + 2) begin miscompares++; $display("FAIL single_ack_cyc got %0d exp %0d", (ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1), c0 + 24); end
        vectors++; if (get_bcd(1) !== 16'h0987) begin miscompares++; $display("FAIL single_bcd got %h exp 0987", get_bcd(1)); end
    endtask

    task automatic test_round_robin;
        int c0;
        logic [15:0] exp_b [4];
        exp_b = '{16'h0001, 16'h0022, 16'h0333, 16'h1023};
        apply_reset();
        set_op(0, 1); set_op(1, 22); set_op(2, 333); set_op(3, 1023);
        pulse_req(4'b1111, c0);
        repeat (120) step;
        vectors++; if (ack_ch_q.size() != 4) begin miscompares++; $display("FAIL rr_count got %0d exp 4", ack_ch_q.size()); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if ((k < ack_ch_q.size() ? ack_ch_q[k] : -1) != k) begin miscompares++; $display("FAIL rr_order[%0d] got %0d exp %0d", k, (k < ack_ch_q.size() ? ack_ch_q[k] : -1), k); end
            vectors++; if (get_bcd(k) !== exp_b[k]) begin miscompares++; $display("FAIL rr_bcd[%0d] got %h exp %h", k, get_bcd(k), exp_b[k]); end
        end
        clear_q();
        set_op(0, 4); set_op(1, 3); set_op(2, 2); set_op(3, 1);
        pulse_req(4'b1111, c0);
        repeat (120) step;
        vectors++; if ((ack_ch_q.size() > 0 ? ack_ch_q[0] : -1) != 0) begin miscompares++; $display("FAIL rr_round2_first got %0d exp 0", (ack_ch_q.size() > 0 ? ack_ch_q[0] : -1)); end
        vectors++; if (get_bcd(0) !== 16'h0004) begin miscompares++; $display("FAIL rr_round2_bcd got %h exp 0004", get_bcd(0)); end
    endtask

    task automatic test_zero_operand;
        int c0;
        clear_q();
        set_op(2, 0);
        pulse_req(4'b0100, c0);
        repeat (10) step;
        vectors++; if (start_cyc_q.size() != 0) begin miscompares++; $display("FAIL zero_no_start got %0d exp 0", start_cyc_q.size()); end
        vectors++; if (ack_ch_q.size() != 1 || ack_ch_q[0] != 2 || ack_cyc_q[0] != c0 + 3) begin miscompares++; $display("FAIL zero_ack got n=%0d cyc=%0d exp ch2 at %0d", ack_ch_q.size(), (ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1), c0 + 3); end
        vectors++; if (get_bcd(2) !== 16'h0000) begin miscompares++; $display("FAIL zero_bcd got %h exp 0000", get_bcd(2)); end
    endtask

    task automatic test_timeout;
        int c0;
        clear_q();
        silent = 1'b1;
        set_op(0, 5);
        pulse_req(4'b0001, c0);
        repeat (300) step;
        vectors++; if (ack_ch_q.size() != 1 || start_cyc_q.size() != 1 || ack_cyc_q[0] != start_cyc_q[0] + 257) begin miscompares++; $display("FAIL tout_ack_cyc got n=%0d cyc=%0d exp start+257", ack_ch_q.size(), (ack_cyc_q.size() > 0 ? ack_cyc_q[0] : -1)); end
        vectors++; if (get_bcd(0) !== 16'hFFFF) begin miscompares++; $display("FAIL tout_bcd got %h exp FFFF", get_bcd(0)); end
        vectors++; if (err !== 4'b0001) begin miscompares++; $display("FAIL tout_err got %b exp 0001", err); end
        silent = 1'b0;
        clear_q();
        set_op(0, 42);
        pulse_req(4'b0001, c0);
        repeat (40) step;
        vectors++; if (get_bcd(0) !== 16'h0042) begin miscompares++; $display("FAIL tout_recover_bcd got %h exp 0042", get_bcd(0)); end
        vectors++; if (err !== 4'b0001) begin miscompares++; $display("FAIL tout_err_sticky got %b exp 0001", err); end
    endtask

    task automatic test_held_req;
        int n;
        clear_q();
        set_op(3, 7); set_op(0, 9);
        step;
        req = 4'b1000;
        for (int i = 0; i < 60; i++) begin
            step;
            if (ack_ch_q.size() > 0) break;
            req = (i == 10) ? 4'b1001 : 4'b1000;
        end
        req = '0;
        repeat (80) step;
        n = ack_ch_q.size();
        vectors++; if (n != 3 || ack_ch_q[0] != 3 || ack_ch_q[1] != 0 || ack_ch_q[2] != 3) begin miscompares++; $display("FAIL held_order got n=%0d first=%0d exp 3,0,3", n, (n > 0 ? ack_ch_q[0] : -1)); end
        vectors++; if (start_cyc_q.size() != 3) begin miscompares++; $display("FAIL held_starts got %0d exp 3", start_cyc_q.size()); end
        vectors++; if (get_bcd(3) !== 16'h0007 || get_bcd(0) !== 16'h0009) begin miscompares++; $display("FAIL held_bcd got %h/%h exp 0007/0009", get_bcd(3), get_bcd(0)); end
    endtask

    task automatic test_reset_mid_wait;
        int c0;
        clear_q();
        set_op(1, 55);
        pulse_req(4'b0010, c0);
        repeat (6) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstw_busy got %b exp 0", busy); end
        vectors++; if (ack !== 4'h0 || err !== 4'h0 || conv_start !== 1'b0) begin miscompares++; $display("FAIL rstw_ctrl got ack=%h err=%h start=%b exp 0", ack, err, conv_start); end
        vectors++; if (bcd_out !== 64'h0 || conv_bin !== 10'h0) begin miscompares++; $display("FAIL rstw_data got bcd=%h bin=%h exp 0", bcd_out, conv_bin); end
        clear_q();
        repeat (30) step;
        vectors++; if (ack_ch_q.size() != 0) begin miscompares++; $display("FAIL rstw_late_done got %0d acks exp 0", ack_ch_q.size()); end
    endtask

    task automatic test_random;
        int c0, ops[4], exp_q[$], last;
        logic [3:0] m;
        model_ptr = 0;
        for (int c = 0; c < 4; c++) model_bcd[c] = 16'h0;
        for (int r = 0; r < 8; r++) begin
            clear_q();
            exp_q.delete();
            m = 4'($urandom_range(1, 15));
            for (int c = 0; c < 4; c++) begin
                ops[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 1023));
                set_op(c, ops[c]);
            end
            for (int k = 0; k < 4; k++) begin
                if (m[(model_ptr + k) % 4]) exp_q.push_back((model_ptr + k) % 4);
            end
            pulse_req(m, c0);
            for (int i = 0; i < 130 && ack_ch_q.size() < exp_q.size(); i++) step;
            repeat (5) step;
            vectors++; if (ack_ch_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand[%0d]_count got %0d exp %0d", r, ack_ch_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                vectors++; if ((k < ack_ch_q.size() ? ack_ch_q[k] : -1) != exp_q[k]) begin miscompares++; $display("FAIL rand[%0d]_order[%0d] got %0d exp %0d", r, k, (k < ack_ch_q.size() ? ack_ch_q[k] : -1), exp_q[k]); end
                model_bcd[exp_q[k]] = to_bcd(ops[exp_q[k]]);
                last = exp_q[k];
            end
            model_ptr = (last + 1) % 4;
            for (int c = 0; c < 4; c++) begin
                vectors++; if (get_bcd(c) !== model_bcd[c]) begin miscompares++; $display("FAIL rand[%0d]_bcd[%0d] got %h exp %h", r, c, get_bcd(c), model_bcd[c]); end
            end
        end
    endtask

    initial begin
        conv_done = 1'b0;
        conv_bcd  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_operand();
        test_timeout();
        test_held_req();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
